seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, clocked successor to the combinational datapath ALU. It adds registered outputs, a valid/ready handshake and an iterative multiply/divide unit that owns the HI/LO registers. Single-cycle ops complete in one cycle. MULT and DIV occupy the unit for WIDTH cycles. It sits between the register-file read stage and the writeback/data-memory stage of the pipeline.

## Interface
- WIDTH, 32: operand/result width; even, ≥ 4.
- OP_W, 5: opcode width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  unit can accept; transfer when in_valid && in_ready.
- op  in  OP_W  operation select.
- a  in  WIDTH  operand 1 (rs).
- b  in  WIDTH  operand 2 (rt/imm/shamt).
- out_valid  out  1  one-cycle pulse: result is valid.
- result  out  WIDTH  registered result.
- result_we  out  1  writeback enable, qualified by out_valid.
- div_zero  out  1  sticky divide-by-zero flag; cleared by the next accepted DIV.

## Operation
- Opcodes: AND 00000, OR 00001, ADD 00010, LUI 00011, MFLO 00100, MFHI 00101, SUB 00110, SLT 00111, SLL 01000, SRA 01001, DIV 01010, MULT 01011, MOVZ 01101. Any other code is a NOP: out_valid=1, result_we=0, result=0.
- ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
- SLT is signed. SLL/SRA shift by b[$clog2(WIDTH)-1:0]. SRA is arithmetic and sign-fills.
- LUI: result = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
- MOVZ: result = a; result_we = (b == 0).
- MULT: unsigned a×b, shift-add, one bit per cycle. Writes {hi, lo} = 2·WIDTH product.
- DIV: unsigned restoring divide, one quotient bit per cycle. Writes lo = quotient, hi = remainder.
- Divide by zero (b == 0): lo = all ones, hi = a, div_zero = 1.
- MULT, DIV: out_valid pulses with result_we=0 and result=lo (new value).
- MFLO/MFHI return the HI/LO contents committed by the last completed MULT/DIV.
- All other valid ops: result_we=1.
- FSM states:
  - IDLE → RUN on accepted MULT/DIV; the counter loads WIDTH.
  - RUN decrements the counter each cycle. At counter==1, HI/LO are committed → DONE.
  - DONE lasts one cycle (out_valid) → IDLE.
- in_ready = (state == IDLE) || (state == DONE).

## Timing
- Reset values: in_ready=1 after reset deasserts; out_valid=0, result=0, result_we=0, div_zero=0, hi=lo=0; state=IDLE.
- Single-cycle op accepted on edge N: out_valid/result on edge N+1. Back-to-back throughput is 1 per cycle.
- MULT/DIV accepted on edge N:
  - in_ready low for cycles N+1 .. N+WIDTH.
  - HI/LO updated at edge N+WIDTH.
  - out_valid at edge N+WIDTH+1.
- A new op can be accepted in the DONE cycle. An MFHI/MFLO accepted there sees the new HI/LO.
- While in_ready=0, in_valid is ignored. Upstream holds its operands (no drop, no queue).
- Reset mid-RUN aborts the operation: HI/LO keep their pre-op values (not partial), no out_valid, return to IDLE.
- out_valid is never asserted in two consecutive cycles for a MULT/DIV.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_AND … OP_MOVZ);
  - the state enum {IDLE, RUN, DONE};
  - the op-kind helper function is_multicycle(op).
- Sub-module seq_muldiv (parameter WIDTH) contains:
  - the FSM and counter;
  - the accumulator/remainder shift registers;
  - the HI/LO registers and div_zero.
- The top module contains the single-cycle op mux, output registers and handshake.

## Test plan
- Reset, then ADD a=0xFFFFFFFF, b=1 → next cycle out_valid=1, result=0, result_we=1. Then SLT a=0xFFFFFFFF, b=0 → result=1.
- SRA a=0x80000000, b=4 → result=0xF8000000. LUI b=0x1234 → result=0x12340000.
- MULT a=0x10000, b=0x10000 → in_ready low 32 cycles, out_valid at N+33. MFHI → 1, MFLO → 0.
- DIV a=100, b=7 → MFLO=14, MFHI=2, div_zero=0. DIV a=5, b=0 → lo=0xFFFFFFFF, hi=5, div_zero=1.
- MOVZ a=9, b=0 → result_we=1, result=9. MOVZ a=9, b=3 → result_we=0.
- MULT with reset asserted at cycle N+10 → no out_valid, in_ready=1, MFLO returns the prior value. Repeat the tests at WIDTH=8: MULT 15×17 → hi=0x00, lo=0xFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, multicycle-unit state type and op classification
// for the sequential ALU.
package alu_pkg;

  localparam int OP_BITS = 5;

  localparam logic [OP_BITS-1:0] OP_AND  = 5'b00000;
  localparam logic [OP_BITS-1:0] OP_OR   = 5'b00001;
  localparam logic [OP_BITS-1:0] OP_ADD  = 5'b00010;
  localparam logic [OP_BITS-1:0] OP_LUI  = 5'b00011;
  localparam logic [OP_BITS-1:0] OP_MFLO = 5'b00100;
  localparam logic [OP_BITS-1:0] OP_MFHI = 5'b00101;
  localparam logic [OP_BITS-1:0] OP_SUB  = 5'b00110;
  localparam logic [OP_BITS-1:0] OP_SLT  = 5'b00111;
  localparam logic [OP_BITS-1:0] OP_SLL  = 5'b01000;
  localparam logic [OP_BITS-1:0] OP_SRA  = 5'b01001;
  localparam logic [OP_BITS-1:0] OP_DIV  = 5'b01010;
  localparam logic [OP_BITS-1:0] OP_MULT = 5'b01011;
  localparam logic [OP_BITS-1:0] OP_MOVZ = 5'b01101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic is_multicycle(input logic [OP_BITS-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Owns the HI/LO architectural registers and the sticky divide-by-zero flag.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             commit,
  output logic [WIDTH-1:0] lo_new,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, opnd_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             div_reg, div_zero_reg;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  // One iteration. Multiply: {acc_hi, acc_lo} is the partial product with the
  // multiplier shifting out of acc_lo. Divide: acc_hi is the remainder and
  // acc_lo shifts the dividend out / quotient in. A zero divisor needs no
  // special case: every step sets a quotient bit and the remainder ends as a.
  always_comb begin
    sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    rem_sh  = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, opnd_reg};
    rem_sub = rem_sh[WIDTH-1:0] - opnd_reg;
    if (div_reg) begin
      step_hi = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
      step_lo = {acc_lo_reg[WIDTH-2:0], rem_ge};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], acc_lo_reg[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready    = (state_reg == IDLE) || (state_reg == DONE);
  assign commit   = (state_reg == RUN) && (cnt_reg == CNT_W'(1));
  assign lo_new   = step_lo;
  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign div_zero = div_zero_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      opnd_reg     <= '0;
      div_reg      <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        cnt_reg    <= CNT_W'(WIDTH);
        acc_hi_reg <= '0;
        acc_lo_reg <= is_div ? a : b;
        opnd_reg   <= is_div ? b : a;
        div_reg    <= is_div;
        if (is_div) div_zero_reg <= (b == '0);
      end else if (state_reg == RUN) begin
        cnt_reg    <= cnt_reg - CNT_W'(1);
        acc_hi_reg <= step_hi;
        acc_lo_reg <= step_lo;
      end
    end
  end

  // A reset that aborts a running op leaves HI/LO at their pre-op values.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_reg != RUN) begin
        hi_reg <= '0;
        lo_reg <= '0;
      end
    end else if (commit) begin
      hi_reg <= step_hi;
      lo_reg <= step_lo;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered-output ALU with valid/ready handshake; single-cycle ops are
// computed here, MULT/DIV are delegated to seq_muldiv.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic             div_zero
);

  localparam int SH_W = $clog2(WIDTH);

  logic [OP_BITS-1:0] opc;
  logic               accept, start;
  logic               md_ready, md_commit;
  logic [WIDTH-1:0]   md_lo_new, hi, lo;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_we;

  logic               out_valid_reg, result_we_reg;
  logic [WIDTH-1:0]   result_reg;

  assign opc      = OP_BITS'(op);
  assign shamt    = b[SH_W-1:0];
  assign in_ready = md_ready;
  assign accept   = in_valid && md_ready;
  assign start    = accept && is_multicycle(opc);

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_div   (opc == OP_DIV),
    .a        (a),
    .b        (b),
    .ready    (md_ready),
    .commit   (md_commit),
    .lo_new   (md_lo_new),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always_comb begin
    alu_res = '0;
    alu_we  = 1'b1;
    case (opc)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFLO: alu_res = lo;
      OP_MFHI: alu_res = hi;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLL:  alu_res = a << shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_MOVZ: begin
        alu_res = a;
        alu_we  = (b == '0);
      end
      // Unassigned codes complete as a NOP with no writeback.
      default: alu_we = 1'b0;
    endcase
  end

  // Commit and single-cycle accept never coincide: commit only fires in RUN,
  // when nothing can be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      result_we_reg <= 1'b0;
    end else if (md_commit) begin
      out_valid_reg <= 1'b1;
      result_reg    <= md_lo_new;
      result_we_reg <= 1'b0;
    end else if (accept && !start) begin
      out_valid_reg <= 1'b1;
      result_reg    <= alu_res;
      result_we_reg <= alu_we;
    end else begin
      out_valid_reg <= 1'b0;
      result_we_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign result_we = result_we_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: 32-bit instance checked through an expected
// queue, plus a WIDTH=8 instance exercised directly.
module tb_seq_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, result_we, div_zero;
  logic [4:0]  op;
  logic [31:0] a, b, result;

  logic        in_valid8, in_ready8, out_valid8, result_we8, div_zero8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, result8;

  seq_alu #(.WIDTH(32), .OP_W(5)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .result(result),
    .result_we(result_we), .div_zero(div_zero)
  );

  seq_alu #(.WIDTH(8), .OP_W(5)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .result(result8),
    .result_we(result_we8), .div_zero(div_zero8)
  );

  typedef struct {
    logic [31:0] res;
    logic        we;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dz = 1'b0;
  int          chk_cnt = 0, pass_cnt = 0, valid_cnt = 0;
  logic [4:0]  rnd_ops [0:12];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference behaviour, written from the instruction definitions.
  task automatic model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    e.res = '0;
    e.we  = 1'b1;
    case (o)
      OP_AND:  e.res = x & y;
      OP_OR:   e.res = x | y;
      OP_ADD:  e.res = x + y;
      OP_SUB:  e.res = x - y;
      OP_LUI:  e.res = {y[15:0], 16'h0000};
      OP_MFLO: e.res = m_lo;
      OP_MFHI: e.res = m_hi;
      OP_SLT:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_SLL:  e.res = x << y[4:0];
      OP_SRA:  e.res = $signed(x) >>> y[4:0];
      OP_MOVZ: begin e.res = x; e.we = (y == 0); end
      OP_MULT: begin
        p = {32'h0, x} * {32'h0, y};
        m_hi = p[63:32]; m_lo = p[31:0];
        e.res = m_lo; e.we = 1'b0;
      end
      OP_DIV: begin
        m_dz = (y == 0);
        if (y == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = x; end
        else begin m_lo = x / y; m_hi = x % y; end
        e.res = m_lo; e.we = 1'b0;
      end
      default: e.we = 1'b0;
    endcase
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                      input bit push = 1'b1);
    int k;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    if (!in_ready) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    if (push) model(o, x, y);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic run8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                      output logic [7:0] r, output logic w);
    int   k;
    logic got;
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1;
    k = 0;
    while (!in_ready8 && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid8) begin got = 1'b1; break; end
    end
    check("w8_out_valid", {63'd0, got}, 64'd1);
    r = result8;
    w = result_we8;
    $display("txn8 op=%b a=%h b=%h result=%h we=%0d", o, x, y, r, w);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) check("spurious_valid", {63'd0, out_valid}, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        $display("txn result=%h we=%0d (exp %h/%0d)", result, result_we, mon_e.res, mon_e.we);
        check("result", result, mon_e.res);
        check("result_we", {63'd0, result_we}, {63'd0, mon_e.we});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int          busy;
    int          v0;
    logic [7:0]  r8;
    logic        w8;
    logic [31:0] rb;

    rnd_ops = '{OP_AND, OP_OR, OP_ADD, OP_LUI, OP_SUB, OP_SLT, OP_SLL,
                OP_SRA, OP_MOVZ, OP_MULT, OP_DIV, OP_MFLO, OP_MFHI};
    reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
    in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_result_we", {63'd0, result_we}, 64'd0);
    check("rst_div_zero", {63'd0, div_zero}, 64'd0);
    check("rst_in_ready8", {63'd0, in_ready8}, 64'd1);

    send(OP_MFLO, 0, 0);
    send(OP_ADD, 32'hFFFF_FFFF, 1);
    send(OP_SLT, 32'hFFFF_FFFF, 0);
    send(OP_SRA, 32'h8000_0000, 4);
    send(OP_LUI, 0, 32'h1234);
    send(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    send(OP_OR, 32'hF000_0000, 32'h0000_000F);
    send(OP_SUB, 5, 7);
    send(OP_SLL, 1, 31);
    send(OP_MOVZ, 9, 0);
    send(OP_MOVZ, 9, 3);
    send(5'b11111, 32'h1234, 32'h5678);
    drain();

    send(OP_MULT, 32'h0001_0000, 32'h0001_0000);
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
      busy++;
    end
    check("mult_busy_cycles", busy, 32);
    check("mult_done_valid", {63'd0, out_valid}, 64'd1);
    send(OP_MFHI, 0, 0);
    send(OP_MFLO, 0, 0);

    send(OP_DIV, 100, 7);
    send(OP_MFLO, 0, 0);
    send(OP_MFHI, 0, 0);
    drain();
    check("div_zero_clear", {63'd0, div_zero}, 64'd0);
    send(OP_DIV, 5, 0);
    send(OP_MFLO, 0, 0);
    send(OP_MFHI, 0, 0);
    drain();
    check("div_zero_set", {63'd0, div_zero}, 64'd1);

    // Abort a MULT with reset ten cycles in; nothing may be produced.
    send(OP_MULT, 3, 4, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_dz = 1'b0;
    v0 = valid_cnt;
    repeat (40) @(negedge clk);
    check("abort_no_valid", valid_cnt, v0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_div_zero", {63'd0, div_zero}, {63'd0, m_dz});
    send(OP_MFLO, 0, 0);
    send(OP_MFHI, 0, 0);
    drain();

    for (int i = 0; i < 16; i++) begin
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      send(rnd_ops[$urandom_range(0, 12)], $urandom, rb);
    end
    drain();
    check("rand_div_zero", {63'd0, div_zero}, {63'd0, m_dz});

    run8(OP_MULT, 8'd15, 8'd17, r8, w8);
    check("w8_mult_lo", r8, 64'hFF);
    check("w8_mult_we", {63'd0, w8}, 64'd0);
    run8(OP_MFHI, 0, 0, r8, w8);
    check("w8_mfhi", r8, 64'h00);
    run8(OP_MFLO, 0, 0, r8, w8);
    check("w8_mflo", r8, 64'hFF);
    run8(OP_DIV, 8'd200, 8'd7, r8, w8);
    check("w8_div_q", r8, 64'd28);
    run8(OP_MFHI, 0, 0, r8, w8);
    check("w8_div_r", r8, 64'd4);
    run8(OP_SRA, 8'h80, 8'd3, r8, w8);
    check("w8_sra", r8, 64'hF0);
    run8(OP_LUI, 0, 8'h5A, r8, w8);
    check("w8_lui", r8, 64'hA0);
    run8(OP_DIV, 8'd9, 8'd0, r8, w8);
    check("w8_divz_lo", r8, 64'hFF);
    check("w8_divz_flag", {63'd0, div_zero8}, 64'd1);
    run8(OP_MFHI, 0, 0, r8, w8);
    check("w8_divz_hi", r8, 64'd9);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
